// File: rtl/mmu_pkg.sv
// Shared types and constants for the MIPS address-translation stage.
package mmu_pkg;

  localparam int PFN_W  = 20;
  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;

  localparam logic [2:0] SEG_KSEG0      = 3'b100;
  localparam logic [2:0] SEG_KSEG1      = 3'b101;
  localparam logic [2:0] CACHE_UNCACHED = 3'd2;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_REFILL  = 2'd1,
    EXC_INVALID = 2'd2,
    EXC_MOD     = 2'd3
  } exc_e;

endpackage

// File: rtl/mmu_seg_decode.sv
// MIPS segment decode: kseg0/kseg1 bypass the TLB, everything else is mapped.
module mmu_seg_decode
  import mmu_pkg::*;
(
  input  logic [2:0] seg,
  output logic       mapped,
  output logic       unmapped_c_sel
);

  // unmapped_c_sel = 1 selects the fixed uncached attribute (kseg1), 0 selects Config.K0
  always_comb begin
    mapped         = 1'b1;
    unmapped_c_sel = 1'b0;
    if (seg == SEG_KSEG0) begin
      mapped = 1'b0;
    end else if (seg == SEG_KSEG1) begin
      mapped         = 1'b0;
      unmapped_c_sel = 1'b1;
    end
  end

endmodule

// File: rtl/mmu_xlate.sv
// Two-stage virtual-to-physical translation: S1 drives the TLB search port,
// S2 holds the physical address, cache attribute and exception class.
module mmu_xlate
  import mmu_pkg::*;
#(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = $clog2(TLB_NUM)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [2:0]        cfg_k0,
  input  logic [ASID_W-1:0] cp0_asid,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vaddr,
  input  logic              req_wr,
  output logic [VPN2_W-1:0] s_vpn2,
  output logic              s_odd_page,
  output logic [ASID_W-1:0] s_asid,
  input  logic              s_found,
  input  logic [IDX_W-1:0]  s_index,
  input  logic [PFN_W-1:0]  s_pfn,
  input  logic [2:0]        s_c,
  input  logic              s_d,
  input  logic              s_v,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_paddr,
  output logic [2:0]        resp_c,
  output logic              resp_mapped,
  output logic [IDX_W-1:0]  resp_index,
  output logic [1:0]        resp_exc,
  output logic              resp_wr,
  output logic [31:0]       resp_vaddr
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a flush kills both stages and blocks accept.
  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_vaddr_q, s1_vaddr_d;
  logic              s1_wr_q, s1_wr_d;
  logic [ASID_W-1:0] s1_asid_q, s1_asid_d;

  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_paddr_q, s2_paddr_d;
  logic [2:0]        s2_c_q, s2_c_d;
  logic              s2_mapped_q, s2_mapped_d;
  logic [IDX_W-1:0]  s2_index_q, s2_index_d;
  exc_e              s2_exc_q, s2_exc_d;
  logic              s2_wr_q, s2_wr_d;
  logic [31:0]       s2_vaddr_q, s2_vaddr_d;

  logic              s1_adv;
  logic              accept;
  logic              drain;
  logic              seg_mapped;
  logic              seg_uncached;

  logic [31:0]       res_paddr;
  logic [2:0]        res_c;
  logic [IDX_W-1:0]  res_index;
  exc_e              res_exc;

  assign s1_adv    = s1_valid_q && (!s2_valid_q || resp_ready);
  assign req_ready = !flush && (!s1_valid_q || s1_adv);
  assign accept    = req_valid && req_ready;
  assign drain     = s2_valid_q && resp_ready;

  assign s_vpn2     = s1_vaddr_q[31:13];
  assign s_odd_page = s1_vaddr_q[12];
  assign s_asid     = s1_asid_q;

  mmu_seg_decode u_seg (
    .seg            (s1_vaddr_q[31:29]),
    .mapped         (seg_mapped),
    .unmapped_c_sel (seg_uncached)
  );

  // Translation result, sampled into S2 only in the cycle S1 advances
  always_comb begin
    res_paddr = {3'b000, s1_vaddr_q[28:0]};
    res_c     = seg_uncached ? CACHE_UNCACHED : cfg_k0;
    res_index = '0;
    res_exc   = EXC_NONE;
    if (seg_mapped) begin
      if (!s_found) begin
        res_exc   = EXC_REFILL;
        res_paddr = '0;
        res_c     = '0;
      end else begin
        res_paddr = {s_pfn, s1_vaddr_q[11:0]};
        res_c     = s_c;
        res_index = s_index;
        if (!s_v) begin
          res_exc = EXC_INVALID;
        end else if (s1_wr_q && !s_d) begin
          res_exc = EXC_MOD;
        end
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_vaddr_d  = s1_vaddr_q;
    s1_wr_d     = s1_wr_q;
    s1_asid_d   = s1_asid_q;
    s2_valid_d  = s2_valid_q;
    s2_paddr_d  = s2_paddr_q;
    s2_c_d      = s2_c_q;
    s2_mapped_d = s2_mapped_q;
    s2_index_d  = s2_index_q;
    s2_exc_d    = s2_exc_q;
    s2_wr_d     = s2_wr_q;
    s2_vaddr_d  = s2_vaddr_q;

    if (accept) begin
      s1_vaddr_d = req_vaddr;
      s1_wr_d    = req_wr;
      s1_asid_d  = cp0_asid;
    end

    if (flush)       s1_valid_d = 1'b0;
    else if (accept) s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;

    if (s1_adv && !flush) begin
      s2_paddr_d  = res_paddr;
      s2_c_d      = res_c;
      s2_mapped_d = seg_mapped;
      s2_index_d  = res_index;
      s2_exc_d    = res_exc;
      s2_wr_d     = s1_wr_q;
      s2_vaddr_d  = s1_vaddr_q;
    end

    if (flush)       s2_valid_d = 1'b0;
    else if (s1_adv) s2_valid_d = 1'b1;
    else if (drain)  s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_vaddr_q  <= '0;
      s1_wr_q     <= 1'b0;
      s1_asid_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_paddr_q  <= '0;
      s2_c_q      <= '0;
      s2_mapped_q <= 1'b0;
      s2_index_q  <= '0;
      s2_exc_q    <= EXC_NONE;
      s2_wr_q     <= 1'b0;
      s2_vaddr_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_vaddr_q  <= s1_vaddr_d;
      s1_wr_q     <= s1_wr_d;
      s1_asid_q   <= s1_asid_d;
      s2_valid_q  <= s2_valid_d;
      s2_paddr_q  <= s2_paddr_d;
      s2_c_q      <= s2_c_d;
      s2_mapped_q <= s2_mapped_d;
      s2_index_q  <= s2_index_d;
      s2_exc_q    <= s2_exc_d;
      s2_wr_q     <= s2_wr_d;
      s2_vaddr_q  <= s2_vaddr_d;
    end
  end

  assign resp_valid  = s2_valid_q;
  assign resp_paddr  = s2_paddr_q;
  assign resp_c      = s2_c_q;
  assign resp_mapped = s2_mapped_q;
  assign resp_index  = s2_index_q;
  assign resp_exc    = s2_exc_q;
  assign resp_wr     = s2_wr_q;
  assign resp_vaddr  = s2_vaddr_q;

endmodule

// File: tb/tb_mmu_xlate.sv
// Randomized scoreboard bench for mmu_xlate with a behavioural TLB and translation model.
module tb_mmu_xlate;

  localparam int RW = 75;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [2:0]  cfg_k0;
  logic [7:0]  cp0_asid;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_wr;
  logic [18:0] s_vpn2;
  logic        s_odd_page;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [19:0] s_pfn;
  logic [2:0]  s_c;
  logic        s_d;
  logic        s_v;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic [2:0]  resp_c;
  logic        resp_mapped;
  logic [3:0]  resp_index;
  logic [1:0]  resp_exc;
  logic        resp_wr;
  logic [31:0] resp_vaddr;

  mmu_xlate dut (
    .clk(clk), .resetn(resetn), .flush(flush), .cfg_k0(cfg_k0), .cp0_asid(cp0_asid),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_wr(req_wr),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_c(resp_c), .resp_mapped(resp_mapped), .resp_index(resp_index),
    .resp_exc(resp_exc), .resp_wr(resp_wr), .resp_vaddr(resp_vaddr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural TLB contents ----------------
  logic [18:0] tlb_vpn2 [16];
  logic [7:0]  tlb_asid [16];
  logic        tlb_g    [16];
  logic [19:0] tlb_pfn0 [16];
  logic [19:0] tlb_pfn1 [16];
  logic [2:0]  tlb_c0   [16];
  logic [2:0]  tlb_c1   [16];
  logic        tlb_v0   [16];
  logic        tlb_v1   [16];
  logic        tlb_d0   [16];
  logic        tlb_d1   [16];

  always_comb begin
    s_found = 1'b0;
    s_index = '0;
    s_pfn   = '0;
    s_c     = '0;
    s_d     = 1'b0;
    s_v     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (tlb_vpn2[i] == s_vpn2 && (tlb_g[i] || tlb_asid[i] == s_asid)) begin
        s_found = 1'b1;
        s_index = i[3:0];
        s_pfn   = s_odd_page ? tlb_pfn1[i] : tlb_pfn0[i];
        s_c     = s_odd_page ? tlb_c1[i]   : tlb_c0[i];
        s_d     = s_odd_page ? tlb_d1[i]   : tlb_d0[i];
        s_v     = s_odd_page ? tlb_v1[i]   : tlb_v0[i];
      end
    end
  end

  // ---------------- reference model ----------------
  // Packed as {paddr, c, mapped, index, exc, wr, vaddr}
  function automatic logic [RW-1:0] predict(input logic [31:0] va, input logic wr,
                                            input logic [7:0] asid);
    logic [31:0] pa;
    logic [2:0]  c;
    logic        mapped;
    logic [3:0]  idx;
    logic [1:0]  exc;
    int          hit;
    int          odd;
    pa = 0; c = 0; mapped = 0; idx = 0; exc = 0; hit = -1;
    if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
      pa = va - 32'h8000_0000;
      c  = cfg_k0;
    end else if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
      pa = va - 32'hA000_0000;
      c  = 3'd2;
    end else begin
      mapped = 1'b1;
      odd    = int'((va / 4096) % 2);
      for (int i = 0; i < 16; i++)
        if (32'(tlb_vpn2[i]) == va / 8192 && (tlb_g[i] || tlb_asid[i] == asid)) hit = i;
      if (hit < 0) begin
        exc = 2'd1;
      end else begin
        idx = hit[3:0];
        pa  = (odd == 1 ? 32'(tlb_pfn1[hit]) : 32'(tlb_pfn0[hit])) * 4096 + va % 4096;
        c   = odd == 1 ? tlb_c1[hit] : tlb_c0[hit];
        if (!(odd == 1 ? tlb_v1[hit] : tlb_v0[hit])) exc = 2'd2;
        else if (wr && !(odd == 1 ? tlb_d1[hit] : tlb_d0[hit])) exc = 2'd3;
      end
    end
    return {pa, c, mapped, idx, exc, wr, va};
  endfunction

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            acc_cnt = 0;
  logic [RW-1:0] got_w;
  logic [RW-1:0] held_val;
  logic          held = 1'b0;
  bit            rand_bp = 1'b0;
  bit            rand_flush = 1'b0;

  assign got_w = {resp_paddr, resp_c, resp_mapped, resp_index, resp_exc, resp_wr, resp_vaddr};

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Stimulus side: every accepted request pushes its predicted response
  always @(negedge clk) begin
    if (resetn && req_valid && req_ready) begin
      exp_q.push_back(predict(req_vaddr, req_wr, cp0_asid));
      acc_cnt++;
    end
  end

  // Monitor: pops on each completed response handshake
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held && resp_valid) chk("resp_stable", 80'(got_w), 80'(held_val));
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got %h expected no response", got_w);
        end else begin
          chk("resp", 80'(got_w), 80'(exp_q.pop_front()));
        end
      end
      held     = resp_valid && !resp_ready;
      held_val = got_w;
      if (flush) begin
        exp_q.delete();
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) resp_ready = ($urandom_range(0, 3) != 0);
    if (rand_flush) flush = ($urandom_range(0, 29) == 0);
  endtask

  task automatic send(input logic [31:0] va, input logic wr);
    int prev;
    int n;
    req_valid = 1'b1;
    req_vaddr = va;
    req_wr    = wr;
    n = 0;
    prev = acc_cnt;
    while (acc_cnt == prev && n < 100) begin
      tick();
      n++;
    end
    if (acc_cnt == prev) chk("accept_timeout", 80'(acc_cnt), 80'(prev + 1));
  endtask

  // Request into an empty pipeline with resp_ready high; checks latency and fields
  task automatic run_one(input string name, input logic [31:0] va, input logic wr,
                         input logic [31:0] pa, input logic [2:0] c, input logic mapped,
                         input logic [3:0] idx, input logic [1:0] exc);
    req_valid = 1'b1;
    req_vaddr = va;
    req_wr    = wr;
    tick();
    req_valid = 1'b0;
    chk({name, "_lat1"}, 80'(resp_valid), 80'(0));
    tick();
    chk(name, 80'({resp_valid, got_w}), 80'({1'b1, pa, c, mapped, idx, exc, wr, va}));
  endtask

  function automatic logic [31:0] rand_vaddr();
    int sel;
    int e;
    sel = int'($urandom_range(0, 3));
    e   = int'($urandom_range(0, 15));
    case (sel)
      0:       return 32'h8000_0000 | ($urandom() & 32'h1FFF_FFFF);
      1:       return 32'hA000_0000 | ($urandom() & 32'h1FFF_FFFF);
      2:       return {tlb_vpn2[e], 13'($urandom())};
      default: return $urandom();
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int prev;
    resetn = 1'b0; flush = 1'b0; cfg_k0 = 3'd3; cp0_asid = 8'h12;
    req_valid = 1'b0; req_vaddr = '0; req_wr = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tlb_vpn2[i] = (i >= 12) ? 19'h60000 + 19'(i) : 19'h00100 + 19'(i);
      tlb_asid[i] = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h13;
      tlb_g[i]    = ($urandom_range(0, 3) == 0);
      tlb_pfn0[i] = 20'($urandom());
      tlb_pfn1[i] = 20'($urandom());
      tlb_c0[i]   = 3'($urandom());
      tlb_c1[i]   = 3'($urandom());
      tlb_v0[i]   = ($urandom_range(0, 3) != 0);
      tlb_v1[i]   = ($urandom_range(0, 3) != 0);
      tlb_d0[i]   = ($urandom_range(0, 1) == 0);
      tlb_d1[i]   = ($urandom_range(0, 1) == 0);
    end
    tlb_vpn2[5] = 19'h00040; tlb_asid[5] = 8'h12; tlb_g[5] = 1'b0;
    tlb_pfn1[5] = 20'h0ABCD; tlb_v1[5] = 1'b1; tlb_d1[5] = 1'b1; tlb_c1[5] = 3'd3;

    tick(); tick();
    chk("rst_resp", 80'(got_w), 80'(0));
    chk("rst_valid_ready", 80'({resp_valid, req_ready}), 80'(2'b01));
    chk("rst_search", 80'({s_vpn2, s_odd_page, s_asid}), 80'(0));
    resetn = 1'b1;
    tick();

    // Unmapped segments and mapped translations
    run_one("kseg0", 32'h8000_1234, 1'b0, 32'h0000_1234, 3'd3, 1'b0, 4'd0, 2'd0);
    run_one("kseg1", 32'hBFC0_0000, 1'b0, 32'h1FC0_0000, 3'd2, 1'b0, 4'd0, 2'd0);
    run_one("hit",   32'h0008_1ABC, 1'b0, 32'h0ABC_DABC, 3'd3, 1'b1, 4'd5, 2'd0);
    cp0_asid = 8'h13;
    run_one("refill", 32'h0008_1ABC, 1'b0, 32'h0, 3'd0, 1'b1, 4'd0, 2'd1);
    cp0_asid = 8'h12;
    tick();
    tlb_v1[5] = 1'b0;
    run_one("invalid", 32'h0008_1ABC, 1'b0, 32'h0ABC_DABC, 3'd3, 1'b1, 4'd5, 2'd2);
    tick();
    tlb_v1[5] = 1'b1; tlb_d1[5] = 1'b0;
    run_one("modified", 32'h0008_1ABC, 1'b1, 32'h0ABC_DABC, 3'd3, 1'b1, 4'd5, 2'd3);
    tick();
    tlb_d1[5] = 1'b1;
    tick();

    // Backpressure: two accepts fill the pipe, then req_ready must drop
    resp_ready = 1'b0;
    send(32'h8000_0010, 1'b0);
    send(32'h0008_1000, 1'b1);
    req_vaddr = 32'hA000_0020;
    req_wr    = 1'b0;
    chk("bp_req_ready", 80'({req_ready, resp_valid}), 80'(2'b01));
    tick();
    resp_ready = 1'b1;
    send(32'hA000_0020, 1'b0);
    send(32'h0008_1ABC, 1'b0);
    req_valid = 1'b0;
    tick(); tick(); tick();

    // Flush with both stages full and a pending request
    resp_ready = 1'b0;
    send(32'h8000_0100, 1'b0);
    send(32'h8000_0200, 1'b0);
    req_vaddr = 32'h8000_0300;
    flush = 1'b1;
    prev = acc_cnt;
    chk("flush_req_ready", 80'({req_ready, resp_valid}), 80'(2'b01));
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_resp_valid", 80'(resp_valid), 80'(0));
    chk("flush_no_accept", 80'(acc_cnt), 80'(prev));
    resp_ready = 1'b1;
    tick(); tick();
    chk("flush_idle", 80'(resp_valid), 80'(0));

    // Asynchronous reset in the middle of a stream
    resp_ready = 1'b0;
    send(32'h8000_0400, 1'b0);
    send(32'h8000_0500, 1'b0);
    req_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_resp_valid", 80'({resp_valid, req_ready}), 80'(2'b01));
    tick(); tick();
    resetn = 1'b1;
    resp_ready = 1'b1;
    tick();
    chk("areset_no_resp", 80'(resp_valid), 80'(0));
    run_one("post_reset", 32'hA000_1000, 1'b0, 32'h0000_1000, 3'd2, 1'b0, 4'd0, 2'd0);
    tick();

    // Randomized traffic with backpressure, ASID changes and occasional flushes
    rand_bp = 1'b1;
    rand_flush = 1'b1;
    for (int n = 0; n < 300; n++) begin
      cp0_asid = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h13;
      send(rand_vaddr(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 1'b0;
        tick();
      end
    end
    req_valid  = 1'b0;
    rand_bp    = 1'b0;
    rand_flush = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", 80'(exp_q.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish before 300000");
    $fatal(1, "timeout");
  end

endmodule
